// File: rtl/hsi_tx_arbiter.sv
// Arbitrates four byte requesters onto one serial line coder, one frame at a time.
// Build option: define HSI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module hsi_tx_arbiter #(
    parameter int GAP_TICKS    = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clk_en,
    input  logic [3:0]  req,
    input  logic [31:0] d_in,
    output logic [3:0]  ack,
    output logic [7:0]  cd_d,
    output logic        cd_d_rdy,
    input  logic        cd_busy,
    output logic [1:0]  grant_id,
    output logic        active,
    output logic        err
);
    // state     | meaning
    // IDLE      | arbitrate on every tick, capture winner byte
    // LOAD      | cd_d presented with cd_d_rdy, ack pulsed on the tick
    // WAIT_BUSY | waiting for the coder to start, bounded by BUSY_TIMEOUT
    // SEND      | coder shifting the frame
    // GAP       | GAP_TICKS stop-level ticks before the next arbitration
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, SEND, GAP} state_t;

    localparam logic [3:0] BUSY_LOAD = 4'(BUSY_TIMEOUT - 1);
    localparam logic [3:0] GAP_LOAD  = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] winner;
    logic       grant;

    assign grant = clk_en && (state == IDLE) && (|req);

`ifdef HSI_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) winner = 2'(i);
        end
    end
`else
    logic [1:0] last_grant;

    // Scan offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        winner = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_grant + 2'(k)]) winner = last_grant + 2'(k);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_grant <= 2'd3;
        end else if (grant) begin
            last_grant <= winner;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack       = 4'd0;
        err       = 1'b0;
        if (clk_en) begin
            unique case (state)
                IDLE: begin
                    if (|req) state_nxt = LOAD;
                end
                LOAD: begin
                    ack[grant_id] = 1'b1;
                    cnt_nxt       = BUSY_LOAD;
                    state_nxt     = WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (cd_busy) begin
                        state_nxt = SEND;
                    end else if (cnt == 4'd0) begin
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                SEND: begin
                    if (!cd_busy) begin
                        if (GAP_TICKS > 0) begin
                            state_nxt = GAP;
                            cnt_nxt   = GAP_LOAD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (cnt == 4'd0) state_nxt = IDLE;
                    else cnt_nxt = cnt - 4'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            cd_d     <= 8'd0;
            grant_id <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (grant) begin
                cd_d     <= d_in[{winner, 3'b000} +: 8];
                grant_id <= winner;
            end
        end
    end

    assign cd_d_rdy = (state == LOAD);
    assign active   = (state != IDLE);

endmodule

// File: doc/hsi_tx_arbiter.md
HSI_TX_ARBITER -- requirements
Module: hsi_tx_arbiter

Interface
REQ-001 Parameter GAP_TICKS, default 2, number of idle clk_en ticks (line held at stop level) inserted after each frame before the next grant; legal range 0..15.
REQ-002 Parameter BUSY_TIMEOUT, default 4, maximum clk_en ticks to wait for cd_busy to rise after a load; legal range 1..15.
REQ-003 clk  input  1  clock, all logic rising-edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 clk_en  input  1  bit-rate tick; the same tick that drives the coder.
REQ-006 req  input  4  per-requester transmit request, level, one bit per requester 0..3.
REQ-007 d_in  input  32  requester bytes, d_in[8i+7:8i] belongs to requester i.
REQ-008 ack  output  4  one-hot, one-clk pulse: byte of requester i accepted.
REQ-009 cd_d  output  8  byte to coder.
REQ-010 cd_d_rdy  output  1  load strobe to coder.
REQ-011 cd_busy  input  1  coder busy (frame shifting).
REQ-012 grant_id  output  2  index of requester currently owning the coder.
REQ-013 active  output  1  high in any state other than IDLE.
REQ-014 err  output  1  one-clk pulse on busy timeout.

Function
REQ-015 FSM states IDLE, LOAD, WAIT_BUSY, SEND, GAP; all state changes occur only on clk cycles with clk_en=1.
REQ-016 IDLE: on a clk_en tick with req!=0, select a winner, register d_in byte of winner into cd_d, set grant_id, go to LOAD; req=0 stays IDLE.
REQ-017 Arbitration round-robin: search starts at (last_grant+1) mod 4, ascending with wrap; last_grant updates on every grant.
REQ-018 cd_d_rdy = 1 exactly while state is LOAD; LOAD lasts one clk_en tick, then WAIT_BUSY.
REQ-019 ack[grant_id] = 1 for the single clk cycle where state=LOAD and clk_en=1; all other ack bits 0.
REQ-020 Byte is captured at grant; d_in/req changes after the grant tick do not affect the frame; req deasserted before ack still yields ack and full frame.
REQ-021 WAIT_BUSY: cd_busy=1 -> SEND; else count ticks, reaching BUSY_TIMEOUT -> pulse err for one clk, go to IDLE, no retry, last_grant retained.
REQ-022 SEND: stay while cd_busy=1; cd_busy=0 on a tick -> GAP (GAP_TICKS>0) or IDLE (GAP_TICKS=0).
REQ-023 GAP: count GAP_TICKS clk_en ticks then IDLE; requests arriving during SEND/GAP wait, none dropped.
REQ-024 cd_d holds its value outside LOAD; grant_id holds last winner until next grant.
REQ-025 Back-to-back: with req held continuously, consecutive frames from the same requester are separated by exactly GAP_TICKS idle ticks plus one IDLE arbitration tick.
REQ-026 clk_en=0 freezes FSM, counters and pointer; outputs hold, ack stays 0.

Reset
REQ-027 n_rst=0 forces immediately: state IDLE, cd_d=0, cd_d_rdy=0, ack=0, grant_id=0, active=0, err=0, counters 0, last_grant=3 (requester 0 wins first).
REQ-028 Reset mid-frame abandons the transfer; no ack or err is issued for it after reset release.

Configuration
REQ-029 Macro HSI_ARB_FIXED_PRIO_EN: defined -> fixed priority, lowest index wins, last_grant unused; undefined -> round-robin per REQ-017; all other behaviour identical.

Verification
REQ-030 Single req[2]=1, d_in byte2=8'hA5, GAP_TICKS=2 -> one ack[2] pulse, cd_d=8'hA5 with cd_d_rdy for one tick, grant_id=2, active falls 2 ticks after cd_busy falls.
REQ-031 req=4'hF held, bytes 11/22/33/44 -> grant order 0,1,2,3,0; cd_d sequence 11,22,33,44,11; with HSI_ARB_FIXED_PRIO_EN grants 0,0,0.
REQ-032 cd_busy tied 0, BUSY_TIMEOUT=4 -> err pulse 4 ticks after LOAD, return to IDLE, next grant goes to next requester in rotation.
REQ-033 req[1] raised during SEND of requester 0 -> no ack[1] until GAP completes; then grant 1 with no frame overlap (cd_d_rdy never high while cd_busy=1).
REQ-034 n_rst pulsed low during SEND -> all outputs at reset values immediately; after release with req[3]=1, requester 3 granted on first tick (req[0]=0).
REQ-035 clk_en held low for 10 clk in LOAD -> cd_d_rdy stays 1, ack stays 0 until the next clk_en tick, then single ack pulse.
